// File: rtl/reg_write_scoreboard.sv
// Producer-side register write scoreboard: counts in-flight writers per register
// from decode issue to writeback release and stalls decode on RAW or capacity hazards.
module reg_write_scoreboard #(
    parameter int NREGS        = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter bit WB_BYPASS    = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_issue_valid,
    input  logic             i_issue_wr,
    input  logic [4:0]       i_issue_rd,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    input  logic             i_rs1_used,
    input  logic             i_rs2_used,
    input  logic             i_rel_valid,
    input  logic [4:0]       i_rel_rd,
    output logic             o_stall,
    output logic [NREGS-1:0] o_busy,
    output logic             o_err
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0] cnt     [NREGS];
    logic [CW-1:0] cnt_nxt [NREGS];
    logic          issue_fire;
    logic          rel_fire;
    logic          rel_bypass;
    logic          rs1_haz;
    logic          rs2_haz;
    logic          cap_haz;
    logic          err_nxt;

    // A write-first register file lets a reader see a value retiring this cycle.
    function automatic logic still_pending(input logic [CW-1:0] c, input logic rel_hit);
        logic [CW-1:0] eff;
        eff = c - CW'(rel_hit && (c != '0));
        return eff != '0;
    endfunction

    always_comb begin
        rel_fire   = i_rel_valid && (i_rel_rd != 5'd0);
        rel_bypass = WB_BYPASS && rel_fire;

        rs1_haz = i_rs1_used && (i_rs1 != 5'd0)
                  && still_pending(cnt[i_rs1], rel_bypass && (i_rel_rd == i_rs1));
        rs2_haz = i_rs2_used && (i_rs2 != 5'd0)
                  && still_pending(cnt[i_rs2], rel_bypass && (i_rel_rd == i_rs2));
        // A same-cycle release does not free a full slot; the issue waits a cycle.
        cap_haz = i_issue_wr && (i_issue_rd != 5'd0)
                  && (cnt[i_issue_rd] == CW'(MAX_INFLIGHT));

        o_stall    = i_issue_valid && (rs1_haz || rs2_haz || cap_haz);
        issue_fire = i_issue_valid && i_issue_wr && (i_issue_rd != 5'd0) && !o_stall;
    end

    always_comb begin
        cnt_nxt[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            logic inc;
            logic rel_hit;
            inc     = issue_fire && (i_issue_rd == 5'(r));
            rel_hit = rel_fire && (i_rel_rd == 5'(r));
            cnt_nxt[r] = cnt[r];
            if (inc && !rel_hit) begin
                cnt_nxt[r] = cnt[r] + CW'(1);
            end else if (rel_hit && !inc && (cnt[r] != '0)) begin
                cnt_nxt[r] = cnt[r] - CW'(1);
            end
        end
        err_nxt = o_err || (rel_fire && (cnt[i_rel_rd] == '0));
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= '0;
            end
            o_err <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            o_err <= err_nxt;
        end
    end

    always_comb begin
        o_busy = '0;
        for (int r = 1; r < NREGS; r++) begin
            o_busy[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Bench for reg_write_scoreboard: a write-first and a non-bypassed instance share
// stimulus; each cycle's expected outputs are queued at drive time and checked at the falling edge.
module tb_reg_write_scoreboard;

    typedef struct {
        string       name;
        logic        iv;
        logic        iw;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        rv;
        logic [4:0]  rr;
        logic        st1;
        logic        st0;
        logic [31:0] busy;
        logic        err;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_issue_valid, i_issue_wr, i_rs1_used, i_rs2_used, i_rel_valid;
    logic [4:0]  i_issue_rd, i_rs1, i_rs2, i_rel_rd;
    logic        stall_b1, stall_b0, err_b1, err_b0;
    logic [31:0] busy_b1, busy_b0;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 i_clk = ~i_clk;

    reg_write_scoreboard #(.NREGS(32), .MAX_INFLIGHT(4), .WB_BYPASS(1'b1)) dut_b1 (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_issue_valid(i_issue_valid), .i_issue_wr(i_issue_wr), .i_issue_rd(i_issue_rd),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
        .i_rel_valid(i_rel_valid), .i_rel_rd(i_rel_rd),
        .o_stall(stall_b1), .o_busy(busy_b1), .o_err(err_b1)
    );

    reg_write_scoreboard #(.NREGS(32), .MAX_INFLIGHT(4), .WB_BYPASS(1'b0)) dut_b0 (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_issue_valid(i_issue_valid), .i_issue_wr(i_issue_wr), .i_issue_rd(i_issue_rd),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
        .i_rel_valid(i_rel_valid), .i_rel_rd(i_rel_rd),
        .o_stall(stall_b0), .o_busy(busy_b0), .o_err(err_b0)
    );

    function automatic vec_t mk(input string name, input logic iv, input logic iw,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic rv,
                                input logic [4:0] rr, input logic st1, input logic st0,
                                input logic [31:0] busy, input logic err);
        vec_t v;
        v.name = name; v.iv = iv; v.iw = iw; v.rd = rd; v.rs1 = rs1; v.u1 = u1;
        v.rs2 = rs2; v.u2 = u2; v.rv = rv; v.rr = rr; v.st1 = st1; v.st0 = st0;
        v.busy = busy; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        i_issue_valid = v.iv; i_issue_wr = v.iw; i_issue_rd = v.rd;
        i_rs1 = v.rs1; i_rs1_used = v.u1; i_rs2 = v.rs2; i_rs2_used = v.u2;
        i_rel_valid = v.rv; i_rel_rd = v.rr;
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge i_clk);
        #1;
        drive(v);
        exp_q.push_back(v);
        @(negedge i_clk);
        e = exp_q.pop_front();
        check({e.name, "_stall_b1"}, 32'(stall_b1), 32'(e.st1));
        check({e.name, "_stall_b0"}, 32'(stall_b0), 32'(e.st0));
        check({e.name, "_busy_b1"}, busy_b1, e.busy);
        check({e.name, "_busy_b0"}, busy_b0, e.busy);
        check({e.name, "_err_b1"}, 32'(err_b1), 32'(e.err));
        check({e.name, "_err_b0"}, 32'(err_b0), 32'(e.err));
    endtask

    initial begin
        vec_t idle;
        idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);

        // Reset held low for two cycles with an issue presented
        i_reset = 1'b0;
        drive(mk("rst", 1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 0, 32'h0, 0));
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            check("rst_stall", 32'(stall_b1 | stall_b0), 32'h0);
            check("rst_busy", busy_b1 | busy_b0, 32'h0);
            check("rst_err", 32'(err_b1 | err_b0), 32'h0);
        end
        drive(idle);
        i_reset = 1'b1;

        //            name        iv iw rd rs1 u1 rs2 u2 rv rr st1 st0 busy        err
        vecs.push_back(mk("idle_x3",   1, 1, 3, 1, 1, 2, 1, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("rel_x3",    0, 0, 0, 0, 0, 0, 0, 1, 3,  0, 0, 32'h8,      0));
        vecs.push_back(mk("raw_iss5",  1, 1, 5, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("raw_c1",    1, 0, 0, 5, 1, 0, 0, 0, 0,  1, 1, 32'h20,     0));
        vecs.push_back(mk("raw_c2",    1, 0, 0, 5, 1, 0, 0, 0, 0,  1, 1, 32'h20,     0));
        vecs.push_back(mk("raw_c3",    1, 0, 0, 5, 1, 0, 0, 0, 0,  1, 1, 32'h20,     0));
        vecs.push_back(mk("raw_c4",    1, 0, 0, 5, 1, 0, 0, 1, 5,  0, 1, 32'h20,     0));
        vecs.push_back(mk("raw_c5",    1, 0, 0, 5, 1, 0, 0, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("dbl_iss7a", 1, 1, 7, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("dbl_iss7b", 1, 1, 7, 0, 0, 0, 0, 0, 0,  0, 0, 32'h80,     0));
        vecs.push_back(mk("dbl_c2",    1, 0, 0, 0, 0, 7, 1, 0, 0,  1, 1, 32'h80,     0));
        vecs.push_back(mk("dbl_c3",    1, 0, 0, 0, 0, 7, 1, 0, 0,  1, 1, 32'h80,     0));
        vecs.push_back(mk("dbl_c4",    1, 0, 0, 0, 0, 7, 1, 1, 7,  1, 1, 32'h80,     0));
        vecs.push_back(mk("dbl_c5",    1, 0, 0, 0, 0, 7, 1, 1, 7,  0, 1, 32'h80,     0));
        vecs.push_back(mk("dbl_c6",    1, 0, 0, 0, 0, 7, 1, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("own_a",     1, 1, 5, 5, 1, 1, 1, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("own_b",     1, 1, 5, 5, 1, 1, 1, 0, 0,  1, 1, 32'h20,     0));
        vecs.push_back(mk("own_rel",   0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 0, 32'h20,     0));
        vecs.push_back(mk("own_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("x0_iss",    1, 1, 0, 0, 1, 0, 1, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("x0_rel",    1, 1, 0, 0, 1, 0, 1, 1, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("x0_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("cap_w1",    1, 1, 9, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("cap_w2",    1, 1, 9, 0, 0, 0, 0, 0, 0,  0, 0, 32'h200,    0));
        vecs.push_back(mk("cap_w3",    1, 1, 9, 0, 0, 0, 0, 0, 0,  0, 0, 32'h200,    0));
        vecs.push_back(mk("cap_w4",    1, 1, 9, 0, 0, 0, 0, 0, 0,  0, 0, 32'h200,    0));
        vecs.push_back(mk("cap_w5",    1, 1, 9, 0, 0, 0, 0, 0, 0,  1, 1, 32'h200,    0));
        vecs.push_back(mk("cap_relw",  1, 1, 9, 0, 0, 0, 0, 1, 9,  1, 1, 32'h200,    0));
        vecs.push_back(mk("cap_fire",  1, 1, 9, 0, 0, 0, 0, 0, 0,  0, 0, 32'h200,    0));
        vecs.push_back(mk("cap_r1",    0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 0, 32'h200,    0));
        vecs.push_back(mk("cap_r2",    0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 0, 32'h200,    0));
        vecs.push_back(mk("cap_r3",    0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 0, 32'h200,    0));
        vecs.push_back(mk("cap_r4",    0, 0, 0, 0, 0, 0, 0, 1, 9,  0, 0, 32'h200,    0));
        vecs.push_back(mk("cap_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,      0));
        vecs.push_back(mk("uf_rel12",  0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 32'h0,      0));
        vecs.push_back(mk("uf_iss4",   1, 1, 4, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,      1));
        vecs.push_back(mk("uf_both4",  1, 1, 4, 0, 0, 0, 0, 1, 4,  0, 0, 32'h10,     1));
        vecs.push_back(mk("uf_hold",   1, 0, 0, 4, 1, 0, 0, 0, 0,  1, 1, 32'h10,     1));
        vecs.push_back(mk("uf_rel4",   0, 0, 0, 0, 0, 0, 0, 1, 4,  0, 0, 32'h10,     1));
        vecs.push_back(mk("uf_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,      1));
        vecs.push_back(mk("mr_iss6",   1, 1, 6, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0,      1));
        vecs.push_back(mk("mr_iss8",   1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 32'h40,     1));
        vecs.push_back(mk("mr_read6",  1, 0, 0, 6, 1, 8, 1, 0, 0,  1, 1, 32'h140,    1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset mid-operation: state clears before any clock edge
        #1;
        i_reset = 1'b0;
        #1;
        check("mr_async_stall", 32'({stall_b1, stall_b0}), 32'h0);
        check("mr_async_busy", busy_b1 | busy_b0, 32'h0);
        check("mr_async_err", 32'({err_b1, err_b0}), 32'h0);
        @(posedge i_clk);
        @(negedge i_clk);
        drive(idle);
        i_reset = 1'b1;
        apply(mk("post_rst",   1, 0, 0, 6, 1, 8, 1, 0, 0,  0, 0, 32'h0,      0));
        apply(mk("post_iss3",  1, 1, 3, 1, 1, 2, 1, 0, 0,  0, 0, 32'h0,      0));
        apply(mk("post_rd3",   1, 0, 0, 0, 0, 3, 1, 0, 0,  1, 1, 32'h8,      0));

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_scoreboard.md
# reg_write_scoreboard

Producer-side hazard tracker for the non-forwarding pipeline. It records every register write that leaves decode and releases the record when that write retires at writeback. It raises a decode stall whenever a source operand has an older, still-pending writer. It pairs with the single-cycle load-stall generator: that block stalls on the consumer side for one cycle after a load, while this block tracks write ownership from issue to retirement.

## Interface
- NREGS, 32, number of architectural registers; index 0 is hard-wired zero and never tracked
- MAX_INFLIGHT, 4, maximum outstanding writers per register; counter width CW = $clog2(MAX_INFLIGHT+1)
- WB_BYPASS, 1, 1 = register file is write-first, so a register retiring this cycle is readable this cycle
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset i_reset, asynchronous, active-low; clock i_clk
- i_issue_valid  in  1  decode holds a valid instruction this cycle
- i_issue_wr  in  1  instruction writes i_issue_rd
- i_issue_rd  in  5  destination register
- i_rs1 / i_rs2  in  5 each  source registers
- i_rs1_used / i_rs2_used  in  1 each  source actually read
- i_rel_valid  in  1  a tracked writer reaches WB this cycle; killed instructions still release
- i_rel_rd  in  5  register being released
- o_stall  out  1  combinational; hold decode this cycle
- o_busy  out  NREGS  registered; bit r = pending count of r is nonzero; bit 0 is always 0
- o_err  out  1  registered, sticky underflow flag

## Operation
- Per-register counter cnt[r], CW bits, for r = 1..NREGS-1. cnt[0] is a constant 0.
- issue_fire = i_issue_valid & i_issue_wr & (i_issue_rd != 0) & !o_stall.
- rel_fire = i_rel_valid & (i_rel_rd != 0).
- Counter update at the clock edge:
  - issue_fire only: cnt[rd] + 1.
  - rel_fire only, with cnt > 0: cnt - 1.
  - Both on the same register: no change.
  - Both on different registers: each updates independently.
- Effective pending count for a hazard check: eff[r] = cnt[r] - (WB_BYPASS & rel_fire & i_rel_rd == r & cnt[r] != 0).
- A source hazard exists when rsX_used, rsX != 0, and eff[rsX] != 0.
- A capacity hazard exists when i_issue_wr, i_issue_rd != 0, and cnt[i_issue_rd] == MAX_INFLIGHT, even if a release on that register happens in the same cycle.
- o_stall = i_issue_valid & (rs1 hazard | rs2 hazard | capacity hazard). It is 0 when i_issue_valid = 0.
- The instruction in decode is never checked against its own rd. For example, add x5,x5,x1 stalls only if an older writer of x5 is pending.
- Underflow: rel_fire while cnt[i_rel_rd] == 0 leaves the counter at 0 and sets o_err. o_err stays 1 until reset.
- The pipeline guarantees exactly one release per issued writer. This block does not flush counters; killed instructions still release at WB.
- No state machine beyond the counters. o_busy[r] = (cnt[r] != 0), taken from the registered counters.

## Timing
- Reset (asynchronous, i_reset = 0): all cnt = 0, o_busy = 0, o_err = 0. o_stall then evaluates to 0 for any inputs.
- Latency:
  - Issue at edge N: the counter is incremented after edge N, and a dependent instruction in decode during cycle N+1 sees it.
  - Release in cycle N with WB_BYPASS = 1: the dependent instruction is unstalled in cycle N itself.
  - Release in cycle N with WB_BYPASS = 0: the dependent instruction is unstalled in cycle N+1.
- o_stall is purely combinational from the inputs and current counters, with no registered delay.
- Reset asserted mid-operation clears all pending state immediately. The pipeline must be flushed under the same reset.
- Deassertion of reset is synchronised outside this block.

## Test plan
- Reset then idle:
  - Stimulus: i_reset = 0 for 2 cycles, release it, issue x3 <- x1,x2 with no prior writers.
  - Required: o_stall = 0 every cycle, o_busy = 0, o_err = 0.
- RAW stall and release (WB_BYPASS = 1):
  - Stimulus: issue x5 writer at cycle 0; from cycle 1, hold a reader of rs1 = x5 in decode; release x5 at cycle 4.
  - Required: o_stall = 1 in cycles 1-3 and 0 in cycle 4; o_busy[5] = 1 in cycles 1-4 and 0 in cycle 5.
- Same scenario with WB_BYPASS = 0:
  - Required: o_stall = 1 in cycles 1-4 and 0 in cycle 5.
- Double writer:
  - Stimulus: two issues to x7 at cycles 0 and 1; releases at cycles 4 and 5; a reader of x7 held in decode.
  - Required: the first release does not unstall the reader; o_stall drops only in cycle 5.
- Capacity and x0:
  - Stimulus: 4 outstanding writers to x9, then a 5th writer to x9; separately, issue writers to x0 and read x0.
  - Required: the 5th writer stalls until a release arrives; x0 never stalls and never increments; o_busy[0] = 0.
- Underflow and simultaneous events:
  - Stimulus: release x12 with cnt = 0; then issue and release x4 in the same cycle with cnt[x4] = 1.
  - Required: o_err = 1 after the first event and stays 1; cnt[x4] remains 1.
